// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish evaluation controller driving an external 32-entry LIFO stack.
// Tokens arrive on a valid/ready handshake; results are pushed back and mirrored on Top.
module rpn_stack_ctrl #(
   parameter int W   = 8,
   parameter int OPW = 3
) (
   input  logic         Clk,
   input  logic         RstN,
   input  logic         In_Valid,
   output logic         In_Ready,
   input  logic         In_Is_Op,
   input  logic [W-1:0] In_Data,
   input  logic         Err_Clr,
   output logic         Stk_Push,
   output logic         Stk_Pop,
   output logic [W-1:0] Stk_Data_In,
   input  logic [W-1:0] Stk_Data_Out,
   input  logic         Stk_Full,
   input  logic         Stk_NotEmpty,
   output logic [W-1:0] Top,
   output logic         Res_Valid,
   output logic         Busy,
   output logic         Err,
   output logic [1:0]   Err_Code
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PUSH_OP = 3'd1;
   localparam logic [2:0] S_POP_B   = 3'd2;
   localparam logic [2:0] S_POP_A   = 3'd3;
   localparam logic [2:0] S_EXEC    = 3'd4;
   localparam logic [2:0] S_PUSH_R  = 3'd5;
   localparam logic [2:0] S_CLR     = 3'd6;
   localparam logic [2:0] S_ERR     = 3'd7;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_MUL   = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;
   localparam logic [2:0] OP_PEEK  = 3'd7;

   localparam logic [1:0] EC_UNDER   = 2'd1;
   localparam logic [1:0] EC_OVER    = 2'd2;
   localparam logic [1:0] EC_ILLEGAL = 2'd3;

   logic [2:0]     r_state;
   logic [2:0]     r_op;
   logic [W-1:0]   r_operand;
   logic [W-1:0]   r_reg_b;
   logic [W-1:0]   r_result;
   logic [W-1:0]   r_top;
   logic           r_res_valid;
   logic           r_err;
   logic [1:0]     r_err_code;
   logic [OPW-1:0] w_opcode;
   logic           w_illegal;
   logic           w_accept;

   // a = deeper entry, b = top entry; PEEK passes the popped entry straight through
   function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      case (op)
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         OP_OR:   alu = a | b;
         OP_XOR:  alu = a ^ b;
         OP_MUL:  alu = a * b;
         OP_PEEK: alu = a;
         default: alu = {W{1'b0}};
      endcase
   endfunction

   assign w_opcode = In_Data[OPW-1:0];

   generate
      if (OPW > 3) begin : g_wide_op
         assign w_illegal = |w_opcode[OPW-1:3];
      end else begin : g_narrow_op
         assign w_illegal = 1'b0;
      end
   endgenerate

   assign In_Ready  = (r_state == S_IDLE) & ~r_err;
   assign w_accept  = In_Valid & In_Ready;
   assign Busy      = (r_state != S_IDLE);
   assign Top       = r_top;
   assign Res_Valid = r_res_valid;
   assign Err       = r_err;
   assign Err_Code  = r_err_code;

   // Stack strobes decode directly from state so reset removes them immediately
   always_comb begin
      Stk_Push    = 1'b0;
      Stk_Pop     = 1'b0;
      Stk_Data_In = {W{1'b0}};
      case (r_state)
         S_PUSH_OP: begin
            Stk_Push    = 1'b1;
            Stk_Data_In = r_operand;
         end
         S_PUSH_R: begin
            Stk_Push    = 1'b1;
            Stk_Data_In = r_result;
         end
         S_POP_B:        Stk_Pop = 1'b1;
         S_POP_A, S_CLR: Stk_Pop = Stk_NotEmpty;
         default: begin
            Stk_Push    = 1'b0;
            Stk_Pop     = 1'b0;
            Stk_Data_In = {W{1'b0}};
         end
      endcase
   end

   // Controller sequencing, operand/result registers and sticky error status
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         r_state     <= S_IDLE;
         r_op        <= 3'd0;
         r_operand   <= {W{1'b0}};
         r_reg_b     <= {W{1'b0}};
         r_result    <= {W{1'b0}};
         r_top       <= {W{1'b0}};
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= 2'd0;
      end else begin
         r_res_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept && !In_Is_Op) begin
                  r_operand <= In_Data;
                  if (Stk_Full) begin
                     r_state    <= S_ERR;
                     r_err      <= 1'b1;
                     r_err_code <= EC_OVER;
                  end else begin
                     r_state <= S_PUSH_OP;
                  end
               end else if (w_accept && w_illegal) begin
                  r_state    <= S_ERR;
                  r_err      <= 1'b1;
                  r_err_code <= EC_ILLEGAL;
               end else if (w_accept) begin
                  r_op <= w_opcode[2:0];
                  if (w_opcode[2:0] == OP_CLEAR) begin
                     r_state <= S_CLR;
                  end else if (!Stk_NotEmpty) begin
                     r_state    <= S_ERR;
                     r_err      <= 1'b1;
                     r_err_code <= EC_UNDER;
                  end else begin
                     r_state <= S_POP_B;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_PUSH_OP: r_state <= S_IDLE;
            S_POP_B:   r_state <= (r_op == OP_PEEK) ? S_EXEC : S_POP_A;
            S_POP_A: begin
               r_reg_b <= Stk_Data_Out;
               if (!Stk_NotEmpty) begin
                  r_state    <= S_ERR;
                  r_err      <= 1'b1;
                  r_err_code <= EC_UNDER;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_result <= alu(r_op, Stk_Data_Out, r_reg_b);
               r_state  <= S_PUSH_R;
            end
            S_PUSH_R: begin
               r_top       <= r_result;
               r_res_valid <= 1'b1;
               r_state     <= S_IDLE;
            end
            S_CLR: begin
               if (!Stk_NotEmpty) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_CLR;
               end
            end
            S_ERR: begin
               if (Err_Clr) begin
                  r_state    <= S_IDLE;
                  r_err      <= 1'b0;
                  r_err_code <= 2'd0;
               end else begin
                  r_state <= S_ERR;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: emulates the 32x8 stack and checks every cycle against a
// token-level model that expands each accepted token into its expected output cycles.
module tb_rpn_stack_ctrl;

   logic       Clk = 1'b0;
   logic       RstN = 1'b0;
   logic       In_Valid = 1'b0;
   logic       In_Ready;
   logic       In_Is_Op = 1'b0;
   logic [7:0] In_Data = 8'd0;
   logic       Err_Clr = 1'b0;
   logic       Stk_Push, Stk_Pop;
   logic [7:0] Stk_Data_In;
   logic [7:0] Stk_Data_Out;
   logic       Stk_Full, Stk_NotEmpty;
   logic [7:0] Top;
   logic       Res_Valid, Busy, Err;
   logic [1:0] Err_Code;

   always #5 Clk = ~Clk;

   rpn_stack_ctrl #(.W(8), .OPW(3)) dut (
      .Clk(Clk), .RstN(RstN), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .In_Is_Op(In_Is_Op), .In_Data(In_Data), .Err_Clr(Err_Clr),
      .Stk_Push(Stk_Push), .Stk_Pop(Stk_Pop), .Stk_Data_In(Stk_Data_In),
      .Stk_Data_Out(Stk_Data_Out), .Stk_Full(Stk_Full), .Stk_NotEmpty(Stk_NotEmpty),
      .Top(Top), .Res_Valid(Res_Valid), .Busy(Busy), .Err(Err), .Err_Code(Err_Code)
   );

   // Stack emulation: not affected by RstN, data out is registered on the pop edge
   logic [7:0] smem [0:31];
   int         scnt = 0;
   logic [7:0] sdout = 8'd0;
   assign Stk_Data_Out = sdout;
   assign Stk_Full     = (scnt == 32);
   assign Stk_NotEmpty = (scnt != 0);

   always @(posedge Clk) begin
      if (Stk_Pop && scnt > 0) begin
         sdout <= smem[5'(scnt - 1)];
         scnt  <= scnt - 1;
      end else if (Stk_Push && scnt < 32) begin
         smem[5'(scnt)] <= Stk_Data_In;
         scnt           <= scnt + 1;
      end
   end

   typedef struct {
      logic       push;
      logic       pop;
      logic [7:0] din;
      logic       busy;
      logic       rdy;
      logic       rv;
      logic [7:0] top;
      logic       err;
      logic [1:0] code;
   } exp_t;

   typedef struct {
      logic       is_op;
      logic [7:0] data;
   } tok_t;

   exp_t       expq[$];
   tok_t       tokq[$];
   logic [7:0] mstk[$];
   logic [7:0] m_top = 8'd0;
   logic       m_err = 1'b0;
   logic [1:0] m_code = 2'd0;
   bit         rand_mode = 1'b0;
   bit         want_clr = 1'b0;
   int         n_vec = 0;
   int         n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_v);
      end
   endtask

   function automatic exp_t idle_entry();
      exp_t e;
      e.push = 1'b0; e.pop = 1'b0; e.din = 8'd0;
      e.busy = m_err; e.rdy = ~m_err; e.rv = 1'b0;
      e.top = m_top; e.err = m_err; e.code = m_code;
      return e;
   endfunction

   function automatic exp_t busy_entry();
      exp_t e;
      e = idle_entry();
      e.busy = 1'b1;
      e.rdy  = 1'b0;
      return e;
   endfunction

   function automatic logic [7:0] calc(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
      int p;
      p = int'(a) * int'(b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         default: return p[7:0];
      endcase
   endfunction

   // Expand one accepted token into the output cycles that must follow it
   task automatic accept(input logic is_op, input logic [7:0] d);
      exp_t e;
      int dep;
      logic [2:0] op;
      logic [7:0] a, b, r;
      dep = mstk.size();
      op  = d[2:0];
      if (!is_op) begin
         if (dep == 32) begin
            m_err = 1'b1; m_code = 2'd2;
         end else begin
            e = busy_entry(); e.push = 1'b1; e.din = d; expq.push_back(e);
            mstk.push_back(d);
         end
      end else if (op == 3'd6) begin
         for (int i = 0; i < dep; i++) begin
            e = busy_entry(); e.pop = 1'b1; expq.push_back(e);
         end
         e = busy_entry(); expq.push_back(e);
         mstk.delete();
      end else if (dep == 0) begin
         m_err = 1'b1; m_code = 2'd1;
      end else if (op == 3'd7) begin
         r = mstk[dep-1];
         e = busy_entry(); e.pop = 1'b1; expq.push_back(e);
         e = busy_entry(); expq.push_back(e);
         e = busy_entry(); e.push = 1'b1; e.din = r; expq.push_back(e);
         m_top = r;
         e = idle_entry(); e.rv = 1'b1; expq.push_back(e);
      end else if (dep == 1) begin
         e = busy_entry(); e.pop = 1'b1; expq.push_back(e);
         e = busy_entry(); expq.push_back(e);
         mstk.delete();
         m_err = 1'b1; m_code = 2'd1;
      end else begin
         b = mstk.pop_back();
         a = mstk.pop_back();
         r = calc(op, a, b);
         e = busy_entry(); e.pop = 1'b1; expq.push_back(e);
         expq.push_back(e);
         e = busy_entry(); expq.push_back(e);
         e = busy_entry(); e.push = 1'b1; e.din = r; expq.push_back(e);
         mstk.push_back(r);
         m_top = r;
         e = idle_entry(); e.rv = 1'b1; expq.push_back(e);
      end
   endtask

   // One clock: compare this cycle's outputs, then drive the inputs for the next edge
   task automatic step();
      exp_t e;
      tok_t t;
      int unsigned sel;
      logic [7:0] rnd;
      logic [2:0] op3;
      @(negedge Clk);
      if (expq.size() > 0) e = expq.pop_front();
      else e = idle_entry();
      chk("Stk_Push", 32'(Stk_Push), 32'(e.push));
      chk("Stk_Pop", 32'(Stk_Pop), 32'(e.pop));
      chk("Stk_Data_In", 32'(Stk_Data_In), 32'(e.din));
      chk("Busy", 32'(Busy), 32'(e.busy));
      chk("In_Ready", 32'(In_Ready), 32'(e.rdy));
      chk("Res_Valid", 32'(Res_Valid), 32'(e.rv));
      chk("Top", 32'(Top), 32'(e.top));
      chk("Err", 32'(Err), 32'(e.err));
      chk("Err_Code", 32'(Err_Code), 32'(e.code));
      In_Valid = 1'b0; In_Is_Op = 1'b0; In_Data = 8'd0; Err_Clr = 1'b0;
      if (rand_mode) begin
         if ($urandom_range(0, 9) < 6) begin
            sel = $urandom_range(0, 15);
            rnd = 8'($urandom);
            In_Valid = 1'b1;
            In_Is_Op = ($urandom_range(0, 9) < 4);
            if (In_Is_Op) begin
               op3 = (sel < 14) ? 3'(sel % 6) : ((sel == 14) ? 3'd7 : 3'd6);
               In_Data = {rnd[7:3], op3};
            end else begin
               In_Data = rnd;
            end
         end
         Err_Clr = ($urandom_range(0, 3) == 0);
      end else begin
         if (tokq.size() > 0 && e.rdy) begin
            t = tokq.pop_front();
            In_Valid = 1'b1; In_Is_Op = t.is_op; In_Data = t.data;
         end
         Err_Clr = want_clr;
      end
      if (In_Valid && e.rdy) accept(In_Is_Op, In_Data);
      if (Err_Clr && e.err) begin
         m_err = 1'b0; m_code = 2'd0;
      end
   endtask

   task automatic put(input logic is_op, input logic [7:0] d);
      tok_t t;
      t.is_op = is_op; t.data = d;
      tokq.push_back(t);
   endtask

   task automatic drain();
      int guard = 0;
      while ((tokq.size() > 0 || expq.size() > 0) && guard < 400) begin
         step();
         guard++;
      end
      if (guard >= 400) begin
         n_vec++; n_bad++;
         $display("FAIL drain_timeout: %0d tokens and %0d cycles still pending", tokq.size(), expq.size());
         tokq.delete();
      end
      step();
   endtask

   task automatic clear_err();
      int guard = 0;
      want_clr = 1'b1;
      while (m_err && guard < 10) begin
         step();
         guard++;
      end
      want_clr = 1'b0;
      step();
   endtask

   initial begin
      repeat (2) @(negedge Clk);
      chk("rst_Top", 32'(Top), 32'h0);
      chk("rst_Busy", 32'(Busy), 32'h0);
      chk("rst_Err", 32'(Err), 32'h0);
      chk("rst_Err_Code", 32'(Err_Code), 32'h0);
      chk("rst_Res_Valid", 32'(Res_Valid), 32'h0);
      chk("rst_Stk_Push", 32'(Stk_Push), 32'h0);
      chk("rst_Stk_Pop", 32'(Stk_Pop), 32'h0);
      chk("rst_In_Ready", 32'(In_Ready), 32'h1);
      RstN = 1'b1;

      put(1'b0, 8'd5); put(1'b0, 8'd3); put(1'b1, 8'd0);
      drain();
      chk("add_Top", 32'(Top), 32'h08);
      chk("add_model", 32'(m_top), 32'h08);
      put(1'b1, 8'd7);
      drain();
      chk("peek_Top", 32'(Top), 32'h08);
      chk("peek_depth", 32'(scnt), 32'd1);
      put(1'b1, 8'd6);
      drain();

      put(1'b0, 8'd3); put(1'b0, 8'd5); put(1'b1, 8'd1);
      drain();
      chk("sub_Top", 32'(Top), 32'hFE);
      chk("sub_model", 32'(m_top), 32'hFE);
      put(1'b0, 8'h20); put(1'b0, 8'h10); put(1'b1, 8'd5);
      drain();
      chk("mul_Top", 32'(Top), 32'h00);
      put(1'b1, 8'd6);
      drain();

      put(1'b1, 8'd0);
      drain();
      chk("empty_add_Err", 32'(Err), 32'h1);
      chk("empty_add_code", 32'(Err_Code), 32'h1);
      chk("empty_add_rdy", 32'(In_Ready), 32'h0);
      clear_err();
      chk("clr_In_Ready", 32'(In_Ready), 32'h1);
      chk("clr_Err", 32'(Err), 32'h0);

      put(1'b0, 8'd7); put(1'b1, 8'd0);
      drain();
      chk("one_add_code", 32'(Err_Code), 32'h1);
      chk("one_add_depth", 32'(scnt), 32'd0);
      clear_err();
      put(1'b1, 8'd7);
      drain();
      chk("peek_empty_code", 32'(Err_Code), 32'h1);
      clear_err();

      for (int i = 0; i < 33; i++) put(1'b0, 8'(i + 1));
      drain();
      chk("full_code", 32'(Err_Code), 32'h2);
      chk("full_depth", 32'(scnt), 32'd32);
      chk("full_flag", 32'(Stk_Full), 32'h1);
      clear_err();
      put(1'b1, 8'd6);
      drain();
      chk("clear_depth", 32'(scnt), 32'd0);

      rand_mode = 1'b1;
      repeat (3000) step();
      rand_mode = 1'b0;
      drain();
      chk("rand_depth", 32'(scnt), 32'(mstk.size()));
      if (m_err) clear_err();
      put(1'b1, 8'd6);
      drain();

      for (int i = 0; i < 4; i++) put(1'b0, 8'(8'h40 + i));
      put(1'b1, 8'd6);
      drain();
      chk("clear4_depth", 32'(scnt), 32'd0);
      chk("clear4_Busy", 32'(Busy), 32'h0);

      put(1'b0, 8'd1); put(1'b0, 8'd2);
      drain();
      put(1'b1, 8'd0);
      step();
      step();
      step();
      chk("popa_Stk_Pop", 32'(Stk_Pop), 32'h1);
      RstN = 1'b0;
      #1;
      chk("arst_Stk_Pop", 32'(Stk_Pop), 32'h0);
      chk("arst_Stk_Push", 32'(Stk_Push), 32'h0);
      chk("arst_Busy", 32'(Busy), 32'h0);
      chk("arst_Top", 32'(Top), 32'h0);
      chk("arst_Res_Valid", 32'(Res_Valid), 32'h0);
      chk("arst_Err", 32'(Err), 32'h0);
      chk("arst_Err_Code", 32'(Err_Code), 32'h0);
      chk("arst_Stk_Data_In", 32'(Stk_Data_In), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
- Reverse-Polish evaluation controller that sits directly upstream of the 32-entry, 8-bit LIFO stack.
- Accepts a stream of operand/operator tokens over a valid/ready handshake and drives the stack's Push/Pop/Data_In.
- Consumes the stack's Data_Out, Full and Empty, performs 8-bit ALU operations, and pushes results back.
- Exposes the last result (Top) and sticky error status to the surrounding datapath.

Parameters:
- W, 8, token/data width; must match stack data width.
- OPW, 3, opcode field width (In_Data[OPW-1:0] when In_Is_Op=1).

Ports:
- Clk  input  1  rising-edge clock.
- RstN  input  1  reset, asynchronous, active-low.
- In_Valid  input  1  token present.
- In_Ready  output  1  controller can accept a token this cycle.
- In_Is_Op  input  1  1 = In_Data is an opcode, 0 = operand.
- In_Data  input  W  operand value or opcode.
- Err_Clr  input  1  clears the sticky error; one-cycle pulse.
- Stk_Push  output  1  to stack Push.
- Stk_Pop  output  1  to stack Pop.
- Stk_Data_In  output  W  to stack Data_In.
- Stk_Data_Out  input  W  from stack Data_Out; valid the cycle after a Pop edge.
- Stk_Full  input  1  from stack Full.
- Stk_NotEmpty  input  1  from stack Empty port; that flag is 1 when the stack holds at least one entry and 0 when it is empty.
- Top  output  W  last value pushed as a result or captured by PEEK.
- Res_Valid  output  1  one-cycle pulse when Top updates.
- Busy  output  1  state != IDLE.
- Err  output  1  sticky error.
- Err_Code  output  2  0 none, 1 underflow, 2 overflow, 3 illegal opcode.

Behaviour:
- Reset (async, RstN=0): state=IDLE; Top=0, Res_Valid=0, Err=0, Err_Code=0, regB=0, result=0.
  - Stk_Push/Stk_Pop decode from state, so both drop to 0 immediately.
  - A pending operation is lost; stack contents are not touched.
- In_Ready = (state==IDLE) & ~Err. A token is accepted on a rising edge with In_Valid & In_Ready. In_Valid while not ready is ignored, not queued.
- Opcodes (A = deeper entry, B = top entry):
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 MUL (low W bits): binary.
  - 6 CLEAR, 7 PEEK.
  - All arithmetic modulo 2^W; no carry or overflow flag.
- States:
  - IDLE, PUSH_OP, POP_B, POP_A, EXEC, PUSH_R, CLR, ERR.
  - Stk_Push=1 only in PUSH_OP and PUSH_R.
  - Stk_Pop=1 only in POP_B, in POP_A when Stk_NotEmpty=1, and in CLR when Stk_NotEmpty=1.
  - Stk_Data_In = operand register in PUSH_OP, result register in PUSH_R, 0 otherwise.
- Operand accepted at edge k:
  - If Stk_Full=1 at acceptance: go to ERR with code 2; no push.
  - Otherwise PUSH_OP during cycle k+1, then IDLE. In_Ready is high again in cycle k+2.
- Binary op accepted at edge k:
  - If Stk_NotEmpty=0: go to ERR with code 1; no pop.
  - Otherwise POP_B in cycle k+1.
  - POP_A in cycle k+2: regB <= Stk_Data_Out at edge k+2. If Stk_NotEmpty=0 in this cycle: ERR with code 1. The single popped entry is lost.
  - EXEC in cycle k+3: result <= Stk_Data_Out op regB at edge k+3.
  - PUSH_R in cycle k+4.
  - Edge k+4: Top <= result, Res_Valid=1 in cycle k+5, state IDLE.
- PEEK:
  - Empty check as for binary ops.
  - POP_B, then EXEC with result <= Stk_Data_Out, then PUSH_R (value restored).
  - Top and Res_Valid update as above; 3 busy cycles.
- CLEAR:
  - CLR state issues one Pop per cycle while Stk_NotEmpty=1.
  - Exits to IDLE in the first cycle Stk_NotEmpty=0.
  - Top is unchanged, no Res_Valid; on an empty stack it takes 1 cycle.
- Illegal opcode: none exist at OPW=3. For OPW>3, codes above 7 go to ERR with code 3.
- ERR:
  - Err=1, Err_Code held, no stack activity.
  - Err_Clr=1 goes to IDLE with Err=0 and Err_Code=0 on the next edge.
  - Err_Clr outside ERR is ignored.
- Result push never overflows (net stack change −1 or 0). Full is checked only for operand pushes.

Test Plan:
- Push 5, push 3, ADD, PEEK -> Stk_Push/Pop sequence as specified; Top=8 with Res_Valid pulse after ADD and again after PEEK; stack depth 1.
- Push 3, push 5, SUB -> Top=0xFE (wrap); push 0x20, push 0x10, MUL -> Top=0x00.
- Empty stack, ADD -> Err=1, Err_Code=1, Stk_Pop never asserted, In_Ready=0; Err_Clr -> In_Ready=1, Err=0.
- Push 7, ADD -> exactly one Pop, then Err_Code=1; a subsequent PEEK after Err_Clr raises underflow.
- 32 operand pushes then a 33rd -> Stk_Full=1, no 33rd Stk_Push, Err_Code=2.
- Push 4 values, CLEAR -> 4 consecutive Pop cycles, Stk_NotEmpty=0, Busy falls; then RstN low during POP_A of an ADD -> Stk_Pop drops asynchronously, all outputs at reset values.
